// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among NUM_REQ requesters, message-granular grants.
// Latency: 1 cycle from request to grant; data path is combinational pass-through (zero added latency).
// Backpressure: tx_ready is forwarded only to the granted requester; everyone else sees req_ready=0.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_data/valid/last    per-requester byte stream (byte i at [8i+7:8i])
//   req_ready              per-requester accept, only ever asserted toward the granted requester
//   tx_data/valid/ready    merged stream toward the UART transmitter
//   grant                  registered one-hot grant, zero while idle
//   busy                   high while a requester holds the grant
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  // A disabled limit still needs a 1-bit counter so the logic stays legal.
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (IDLE_TMO > 0) ? $clog2(IDLE_TMO + 1) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST   = TW'((IDLE_TMO > 0) ? IDLE_TMO - 1 : 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] g_idx;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          arb_found;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] cand;
  logic [IW-1:0] g_next;
  logic [7:0]    sel_data;
  logic          xfer;
  logic          g_valid;
  logic          g_last;
  logic          beat;
  logic          burst_hit;
  logic          tmo_hit;
  logic          rel;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Grant is one-hot, so OR-reduce / mux by grant bit instead of indexing by g_idx.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = req_data[8*i +: 8];
    end
  end

  assign xfer     = (state == ST_XFER);
  assign g_valid  = |(req_valid & grant);
  assign g_last   = |(req_last & grant);
  assign tx_data  = sel_data;
  assign tx_valid = xfer & g_valid;
  assign req_ready = (xfer && tx_ready) ? grant : '0;
  assign busy     = xfer;
  assign beat     = tx_valid & tx_ready;

  assign burst_hit = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);
  // Only a silent requester can time out; a stalled UART never forces a release.
  assign tmo_hit   = (IDLE_TMO != 0) && !g_valid && (tmo_cnt == TMO_LAST);
  // Last and burst limit on the same beat collapse into a single release.
  assign rel       = xfer && ((beat && (g_last || burst_hit)) || tmo_hit);
  assign g_next    = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            state     <= ST_XFER;
            g_idx     <= arb_idx;
            grant     <= NUM_REQ'(1) << arb_idx;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
          end
        end
        default: begin
          if (rel) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= g_next;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
          end else if (beat) begin
            if (burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
            tmo_cnt <= '0;
          end else if (g_valid) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (limited burst/timeout and unlimited/disabled).
// Per-requester source queues feed the DUTs; a scoreboard checks every delivered byte in order.
// Arbitration order is checked against a table of request masks and expected grant sequences.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] rq_data  [2];
  logic [3:0]  rq_valid [2];
  logic [3:0]  rq_last  [2];
  logic [3:0]  rq_ready [2];
  logic [3:0]  gnt      [2];
  logic [7:0]  tx_dat   [2];
  logic        tx_vld   [2];
  logic        tx_rdy   [2];
  logic        bsy      [2];

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_TMO(8)) dut_a (
    .clk(clk), .reset_n(rst_n),
    .req_data(rq_data[0]), .req_valid(rq_valid[0]), .req_last(rq_last[0]), .req_ready(rq_ready[0]),
    .tx_data(tx_dat[0]), .tx_valid(tx_vld[0]), .tx_ready(tx_rdy[0]),
    .grant(gnt[0]), .busy(bsy[0])
  );

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(0), .IDLE_TMO(0)) dut_b (
    .clk(clk), .reset_n(rst_n),
    .req_data(rq_data[1]), .req_valid(rq_valid[1]), .req_last(rq_last[1]), .req_ready(rq_ready[1]),
    .tx_data(tx_dat[1]), .tx_valid(tx_vld[1]), .tx_ready(tx_rdy[1]),
    .grant(gnt[1]), .busy(bsy[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_mode = 1'b0;

  logic [8:0] src_q [2][4][$];   // {last, data} still to be presented
  logic [7:0] exp_q [2][4][$];   // bytes expected on tx, per requester, in order
  int         log_idx [2][$];    // requester index of each observed beat
  int         log_cyc [2][$];    // cycle number of each observed beat
  logic [3:0] acc [2];

  typedef struct {
    logic [3:0] mask;
    int         n;
    int         ord [4];
  } rr_vec_t;
  rr_vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic push_msg(input int k, input int i, input int n, input logic [7:0] base, input bit close);
    for (int j = 0; j < n; j++) begin
      src_q[k][i].push_back({(close && j == n - 1), base + 8'(j)});
      exp_q[k][i].push_back(base + 8'(j));
    end
  endtask

  task automatic mon(input int k);
    logic [3:0] g;
    bit ok;
    int idx;
    logic [7:0] e;
    g  = gnt[k];
    ok = $onehot0(g) && ((rq_ready[k] & ~g) == 4'b0) && (bsy[k] == (g != 4'b0))
         && (tx_vld[k] == |(rq_valid[k] & g))
         && ((g == 4'b0) || (rq_ready[k] == (tx_rdy[k] ? g : 4'b0)));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL inv%0d: grant=%b req_ready=%b busy=%b tx_valid=%b at cycle %0d",
               k, g, rq_ready[k], bsy[k], tx_vld[k], cyc);
    end
    if (tx_vld[k] && tx_rdy[k]) begin
      idx = onehot_idx(g);
      log_idx[k].push_back(idx);
      log_cyc[k].push_back(cyc);
      checks++;
      if (exp_q[k][idx].size() == 0) begin
        failures++;
        $display("FAIL sb%0d: unexpected byte %0h from req %0d", k, tx_dat[k], idx);
      end else begin
        e = exp_q[k][idx].pop_front();
        if (tx_dat[k] !== e) begin
          failures++;
          $display("FAIL sb%0d: req %0d byte got %0h expected %0h", k, idx, tx_dat[k], e);
        end
      end
    end
  endtask

  // Requester models and output monitor: sample at negedge, drive 1 time unit after posedge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      rq_valid[k] = '0;
      rq_last[k]  = '0;
      rq_data[k]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc[k] = rst_n ? (rq_valid[k] & rq_ready[k]) : 4'b0;
        if (rst_n) mon(k);
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (acc[k][i] && src_q[k][i].size() > 0) void'(src_q[k][i].pop_front());
          // Hold a pending byte stable until accepted.
          if (!rst_n || !rq_valid[k][i] || acc[k][i]) begin
            if (src_q[k][i].size() > 0 && (!rand_mode || $urandom_range(0, 99) < 80)) begin
              rq_valid[k][i]       = 1'b1;
              rq_data[k][8*i +: 8] = src_q[k][i][0][7:0];
              rq_last[k][i]        = src_q[k][i][0][8];
            end else begin
              rq_valid[k][i] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic wait_beats(input int k, input int n, input int budget, input string name);
    int t = 0;
    while (log_idx[k].size() < n && t < budget) begin
      @(posedge clk); #2;
      t++;
    end
    chk({name, "_done"}, (log_idx[k].size() >= n), 1);
  endtask

  task automatic wait_busy(input int k, input string name);
    int t = 0;
    while (!bsy[k] && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    chk({name, "_busy"}, bsy[k], 1);
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    bit pending = 1'b1;
    while (pending && t < 300) begin
      @(posedge clk); #2;
      t++;
      pending = (gnt[k] != 4'b0);
      for (int i = 0; i < 4; i++) if (src_q[k][i].size() > 0) pending = 1'b1;
    end
    chk("idle_reached", pending, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_log(input int k, input string name, input int exp[$]);
    chk({name, "_count"}, log_idx[k].size(), exp.size());
    for (int j = 0; j < exp.size() && j < log_idx[k].size(); j++)
      chk({name, "_grant"}, log_idx[k][j], exp[j]);
  endtask

  initial begin
    int eq[$];
    int n_low;
    int t;
    bit hold_ok;
    bit pend;

    tbl[0] = '{4'b1111, 4, '{3, 0, 1, 2}};
    tbl[1] = '{4'b0101, 2, '{0, 2, 0, 0}};
    tbl[2] = '{4'b0110, 2, '{1, 2, 0, 0}};
    tbl[3] = '{4'b1000, 1, '{3, 0, 0, 0}};
    tbl[4] = '{4'b1111, 4, '{0, 1, 2, 3}};
    tbl[5] = '{4'b1010, 2, '{1, 3, 0, 0}};

    rst_n     = 1'b0;
    tx_rdy[0] = 1'b0;
    tx_rdy[1] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", tx_vld[0], 0);
    chk("rst_grant", gnt[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_req_ready", rq_ready[0], 0);
    chk("rst_grant_b", gnt[1], 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Async reset in the middle of a stalled transfer
    push_msg(0, 1, 3, 8'h30, 1'b1);
    wait_busy(0, "pre_rst");
    @(negedge clk);
    chk("pre_rst_tx_valid", tx_vld[0], 1);
    chk("pre_rst_grant", gnt[0], 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", tx_vld[0], 0);
    chk("async_rst_grant", gnt[0], 0);
    chk("async_rst_busy", bsy[0], 0);
    for (int i = 0; i < 4; i++) begin
      src_q[0][i].delete();
      exp_q[0][i].delete();
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tx_rdy[0] = 1'b1;
    log_idx[0].delete(); log_cyc[0].delete();
    push_msg(0, 2, 1, 8'h52, 1'b1);
    push_msg(0, 0, 1, 8'h50, 1'b1);
    wait_beats(0, 2, 20, "post_rst");
    eq = '{0, 2};
    check_log(0, "post_rst", eq);
    wait_idle(0);

    // Round-robin table: one-byte messages from the masked requesters
    for (int r = 0; r < 6; r++) begin
      log_idx[0].delete(); log_cyc[0].delete();
      for (int i = 0; i < 4; i++)
        if (tbl[r].mask[i]) push_msg(0, i, 1, 8'(16 * r + i + 1), 1'b1);
      wait_beats(0, tbl[r].n, 40, "rr");
      eq.delete();
      for (int j = 0; j < tbl[r].n; j++) eq.push_back(tbl[r].ord[j]);
      check_log(0, "rr", eq);
      for (int j = 1; j < tbl[r].n && j < log_cyc[0].size(); j++)
        chk("rr_spacing", log_cyc[0][j] - log_cyc[0][j-1], 2);
      wait_idle(0);
    end

    // Message lock on the unlimited instance
    tx_rdy[1] = 1'b1;
    log_idx[1].delete(); log_cyc[1].delete();
    push_msg(1, 0, 5, 8'hA0, 1'b1);
    push_msg(1, 1, 2, 8'hB0, 1'b1);
    wait_beats(1, 7, 60, "lock");
    eq = '{0, 0, 0, 0, 0, 1, 1};
    check_log(1, "lock", eq);
    for (int j = 1; j < 5 && j < log_cyc[1].size(); j++)
      chk("lock_back_to_back", log_cyc[1][j] - log_cyc[1][j-1], 1);
    if (log_cyc[1].size() >= 6) chk("lock_switch_gap", log_cyc[1][5] - log_cyc[1][4], 2);
    wait_idle(1);

    // Timeout disabled: a silent holder keeps the grant
    log_idx[1].delete(); log_cyc[1].delete();
    push_msg(1, 2, 1, 8'hC0, 1'b0);
    wait_beats(1, 1, 20, "notmo");
    repeat (300) @(posedge clk);
    #2;
    chk("notmo_grant_held", gnt[1], 4'b0100);
    chk("notmo_busy", bsy[1], 1);
    push_msg(1, 2, 1, 8'hC1, 1'b1);
    wait_beats(1, 2, 20, "notmo_end");
    wait_idle(1);
    eq = '{2, 2};
    check_log(1, "notmo", eq);

    // Burst limit 4: req1 long message interleaved with req3
    log_idx[0].delete(); log_cyc[0].delete();
    push_msg(0, 1, 20, 8'h00, 1'b1);
    push_msg(0, 3, 2, 8'hE0, 1'b1);
    wait_beats(0, 22, 200, "burst");
    eq = '{1, 1, 1, 1, 3, 3};
    for (int j = 0; j < 16; j++) eq.push_back(1);
    check_log(0, "burst", eq);
    wait_idle(0);

    // Idle timeout 8: two bytes, then silence
    push_msg(0, 0, 2, 8'h70, 1'b0);
    wait_busy(0, "tmo");
    n_low = 0;
    t = 0;
    while (t < 60) begin
      @(negedge clk);
      if (gnt[0] == 4'b0) break;
      if (!tx_vld[0]) n_low++;
      t++;
    end
    chk("tmo_low_cycles", n_low, 8);
    chk("tmo_released", gnt[0], 0);

    // UART stall with valid held high never times out
    @(posedge clk); #2;
    tx_rdy[0] = 1'b0;
    push_msg(0, 1, 1, 8'h71, 1'b1);
    wait_busy(0, "bp");
    hold_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (gnt[0] != 4'b0010 || !tx_vld[0]) hold_ok = 1'b0;
    end
    chk("bp_no_release", hold_ok, 1);
    @(posedge clk); #2;
    tx_rdy[0] = 1'b1;
    wait_idle(0);

    // Random traffic with 30% tx_ready
    log_idx[0].delete(); log_cyc[0].delete();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 1500; j++)
        push_msg(0, i, 1, 8'(j), ($urandom_range(0, 3) == 0) || (j == 1499));
    rand_mode = 1'b1;
    t = 0;
    pend = 1'b1;
    while (pend && t < 60000) begin
      @(posedge clk); #2;
      tx_rdy[0] = ($urandom_range(0, 99) < 30);
      t++;
      pend = 1'b0;
      for (int i = 0; i < 4; i++) if (src_q[0][i].size() > 0) pend = 1'b1;
    end
    chk("rand_drained", pend, 0);
    rand_mode = 1'b0;
    tx_rdy[0] = 1'b1;
    wait_idle(0);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        chk("sb_empty", exp_q[k][i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
